// File: rtl/adc_axis_frame_ctrl_if.sv
// Stream side of the ADC frame sequencer: AXI-Stream style beat bus.
interface adc_axis_frame_ctrl_if #(
    parameter int AXIS_TDATA_WIDTH = 32
);
    logic [AXIS_TDATA_WIDTH-1:0] tdata;
    logic                        tvalid;
    logic                        tready;
    logic                        tlast;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/adc_axis_frame_ctrl.sv
// ADC capture sequencer: admits frame_len valid samples after a start,
// buffers them in a first-word-fall-through FIFO towards the stream, flags
// the final beat with tlast, pulses done after it leaves and counts drops.
module adc_axis_frame_ctrl #(
    parameter int ADC_WIDTH        = 16,
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int FRAME_LEN_WIDTH  = 16,
    parameter int FIFO_DEPTH       = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [FRAME_LEN_WIDTH-1:0] frame_len,
    input  logic [ADC_WIDTH-1:0]       adc_data_in,
    input  logic                       adc_data_valid,
    adc_axis_frame_ctrl_if.master      s_axis_out,
    output logic                       busy,
    output logic                       done,
    output logic [15:0]                overflow_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    typedef struct packed {
        logic                 last;
        logic [ADC_WIDTH-1:0] sample;
    } entry_t;

    state_t                     state;
    logic [FRAME_LEN_WIDTH-1:0] len_q;
    logic [FRAME_LEN_WIDTH-1:0] cnt;
    logic [FRAME_LEN_WIDTH-1:0] cnt_inc;
    entry_t                     mem [FIFO_DEPTH];
    entry_t                     head;
    logic [AW:0]                wr_ptr;
    logic [AW:0]                rd_ptr;
    logic                       empty;
    logic                       full;
    logic                       pop;
    logic                       push_ok;
    logic                       push;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign pop     = !empty && s_axis_out.tready;
    // A full buffer still takes a sample when the head leaves in the same cycle.
    assign push_ok = !full || pop;
    assign push    = (state == CAPTURE) && adc_data_valid && push_ok && !abort;
    assign cnt_inc = cnt + 1'b1;

    // Head entry is gated by empty so the bus reads all-zero while idle/reset.
    assign s_axis_out.tvalid = !empty;
    assign s_axis_out.tdata  = empty ? '0 : AXIS_TDATA_WIDTH'(head.sample);
    assign s_axis_out.tlast  = !empty && head.last;

    assign busy = (state != IDLE);

    // Frame sequencing: latch length, count admitted samples, count drops, finish on last pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            len_q        <= '0;
            cnt          <= '0;
            overflow_cnt <= '0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && frame_len != '0) begin
                            state        <= CAPTURE;
                            len_q        <= frame_len;
                            cnt          <= '0;
                            overflow_cnt <= '0;
                        end
                    end
                    CAPTURE: begin
                        if (adc_data_valid) begin
                            if (push_ok) begin
                                cnt <= cnt_inc;
                                if (cnt_inc == len_q) state <= DRAIN;
                            end else if (overflow_cnt != 16'hFFFF) begin
                                overflow_cnt <= overflow_cnt + 16'd1;
                            end
                        end
                    end
                    DRAIN: begin
                        if (pop && head.last) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // FIFO pointers; abort flushes the buffer in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage; the sample that completes the frame carries the last flag.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= '{last: (cnt_inc == len_q), sample: adc_data_in};
    end
endmodule

// File: tb/tb_adc_axis_frame_ctrl.sv
// Bench for adc_axis_frame_ctrl: directed scenarios plus randomized frames,
// every cycle compared against a queue-based frame model.
module tb_adc_axis_frame_ctrl;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] frame_len;
    logic [15:0] adc_data_in;
    logic        adc_data_valid;
    logic        busy;
    logic        done;
    logic [15:0] overflow_cnt;

    adc_axis_frame_ctrl_if #(.AXIS_TDATA_WIDTH(32)) axis ();

    adc_axis_frame_ctrl #(
        .ADC_WIDTH(16), .AXIS_TDATA_WIDTH(32), .FRAME_LEN_WIDTH(16), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .frame_len(frame_len),
        .adc_data_in(adc_data_in), .adc_data_valid(adc_data_valid),
        .s_axis_out(axis), .busy(busy), .done(done), .overflow_cnt(overflow_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        last;
        logic [15:0] s;
    } ent_t;

    // Reference model: a queue of pending beats plus frame bookkeeping.
    ent_t mq[$];
    int   m_mode;   // 0 idle, 1 capturing, 2 waiting for last beat to leave
    int   m_len;
    int   m_cnt;
    int   m_ovf;
    bit   m_done;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_mode = 0; m_len = 0; m_cnt = 0; m_ovf = 0; m_done = 0;
    endtask

    task automatic model_step(input logic st, input logic ab, input logic [15:0] len,
                              input logic [15:0] din, input logic dv, input logic tr);
        bit pop, plast, room;
        int sz;
        sz    = mq.size();
        pop   = (sz > 0) && tr;
        plast = 0;
        if (pop) plast = mq[0].last;
        room  = (sz < DEPTH) || pop;
        m_done = 0;
        if (ab) begin
            mq.delete();
            m_mode = 0;
            return;
        end
        if (pop) void'(mq.pop_front());
        case (m_mode)
            0: if (st && len != 0) begin
                m_mode = 1; m_len = int'(len); m_cnt = 0; m_ovf = 0;
            end
            1: if (dv) begin
                if (room) begin
                    m_cnt++;
                    mq.push_back('{last: (m_cnt == m_len), s: din});
                    if (m_cnt == m_len) m_mode = 2;
                end else if (m_ovf < 65535) begin
                    m_ovf++;
                end
            end
            default: if (plast) begin
                m_mode = 0; m_done = 1;
            end
        endcase
    endtask

    task automatic check_outputs();
        chk("tvalid", 32'(axis.tvalid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("tdata", axis.tdata, {16'h0, mq[0].s});
            chk("tlast", 32'(axis.tlast), 32'(mq[0].last));
        end else begin
            chk("tlast_idle", 32'(axis.tlast), 32'(0));
        end
        chk("busy", 32'(busy), 32'(m_mode != 0));
        chk("done", 32'(done), 32'(m_done));
        chk("overflow_cnt", 32'(overflow_cnt), 32'(m_ovf));
    endtask

    // One clock: check current outputs, drive inputs, advance the model.
    task automatic cyc(input logic st, input logic ab, input logic [15:0] len,
                       input logic [15:0] din, input logic dv, input logic tr);
        check_outputs();
        start = st; abort = ab; frame_len = len;
        adc_data_in = din; adc_data_valid = dv; axis.tready = tr;
        model_step(st, ab, len, din, dv, tr);
        @(negedge clk);
    endtask

    task automatic mid_reset();
        start = 0; abort = 0; adc_data_valid = 0;
        #2 rst = 1'b1;
        #1;
        chk("rst_tvalid", 32'(axis.tvalid), 32'(0));
        chk("rst_tdata", axis.tdata, 32'(0));
        chk("rst_tlast", 32'(axis.tlast), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_ovf", 32'(overflow_cnt), 32'(0));
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 0; abort = 0; frame_len = 0;
        adc_data_in = 0; adc_data_valid = 0; axis.tready = 0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        chk("reset_tdata", axis.tdata, 32'(0));
        rst = 1'b0;

        // Basic frame of 4 with the sink always ready.
        cyc(1, 0, 16'd4, 16'h0, 0, 1);
        for (int k = 1; k <= 4; k++) cyc(0, 0, 0, 16'(k), 1, 1);
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 16'h0, 0, 1);
        chk("basic_ovf", 32'(overflow_cnt), 32'(0));

        // Backpressure: 10 stalled cycles fill 8 and drop 2, then full-with-pop accepts.
        cyc(1, 0, 16'd12, 16'h0, 0, 0);
        for (int k = 1; k <= 10; k++) cyc(0, 0, 0, 16'(k), 1, 0);
        chk("bp_ovf_stalled", 32'(overflow_cnt), 32'(2));
        for (int k = 11; k <= 30; k++) cyc(0, 0, 0, 16'(k), 1, 1);
        chk("bp_ovf_after_pop", 32'(overflow_cnt), 32'(2));

        // Ignored starts: zero length, restart during capture, samples while idle.
        cyc(1, 0, 16'd0, 16'h55, 1, 1);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 16'h66, 1, 1);
        cyc(1, 0, 16'd3, 16'h0, 0, 1);
        cyc(0, 0, 0, 16'hA1, 1, 1);
        cyc(1, 0, 16'd10, 16'hA2, 1, 1);
        for (int k = 0; k < 6; k++) cyc(0, 0, 0, 16'(16'hB0 + k), 1, 1);

        // Abort mid-frame under backpressure, then a short frame.
        cyc(1, 0, 16'd16, 16'h0, 0, 0);
        for (int k = 0; k < 5; k++) cyc(0, 0, 0, 16'(16'hC0 + k), 1, 0);
        cyc(0, 1, 0, 16'hCF, 1, 0);
        chk("abort_tvalid", 32'(axis.tvalid), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        cyc(1, 0, 16'd2, 16'h0, 0, 1);
        for (int k = 0; k < 6; k++) cyc(0, 0, 0, 16'(16'hD0 + k), 1, 1);

        // Reset while draining with 3 beats pending.
        cyc(1, 0, 16'd3, 16'h0, 0, 0);
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 16'(16'hE0 + k), 1, 0);
        mid_reset();
        for (int k = 0; k < 5; k++) cyc(0, 0, 0, 16'(16'hF0 + k), 1, 1);

        // Randomized frames with random valid density, backpressure, stray starts and aborts.
        for (int f = 0; f < 60; f++) begin
            int len;
            int pv;
            int pr;
            len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20));
            pv  = int'($urandom_range(30, 100));
            pr  = int'($urandom_range(0, 100));
            cyc(1, 0, 16'(len), 16'($urandom), 1'($urandom), 1'($urandom));
            for (int c = 0; c < len * 2 + 10; c++)
                cyc($urandom_range(0, 15) == 0, $urandom_range(0, 150) == 0,
                    16'($urandom_range(0, 20)), 16'($urandom),
                    $urandom_range(1, 100) <= pv, $urandom_range(1, 100) <= pr);
            for (int c = 0; c < 300 && (m_mode != 0 || mq.size() > 0); c++)
                cyc(0, 0, 0, 16'($urandom), 1'($urandom), 1);
            cyc(0, 0, 0, 16'($urandom), 1'($urandom), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
